// File: rtl/argmax_classifier.sv
// argmax_classifier
//   Back end of the final dense layer. After a start pulse it waits for the
//   serial accumulation and ReLU to settle. It then snapshots the score vector
//   and scans it one entry per cycle for the largest signed score. The winning
//   class index is offered on a valid/ready handshake.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-high
//   start        1-cycle pulse: final layer begins accumulating this cycle
//   scores_in    signed score vector, entry i in scores_in[i]
//   class_ready  downstream accepts result
//   class_valid  class_idx holds a valid result
//   class_idx    index of the max score (lowest index wins ties)
//   class_score  best score, only present when ARGMAX_SCORE_OUT_EN is defined
//   busy         high whenever the FSM is not idle
//
// Build option
//   ARGMAX_SCORE_OUT_EN : adds the class_score output port.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// WAIT  | settle timer running; snapshot taken on terminal count
// SCAN  | compare one snapshot entry per cycle against the running best
// HOLD  | result presented until class_valid && class_ready

module argmax_classifier #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_SIZE   = 3,
  parameter int SETTLE_CYC = 34,
  parameter int CLASS_W    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [OUT_SIZE-1:0][DATA_WIDTH-1:0] scores_in,
  input  logic                                class_ready,
  output logic                                class_valid,
  output logic [CLASS_W-1:0]                  class_idx,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic signed [DATA_WIDTH-1:0]        class_score,
`endif
  output logic                                busy
);

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, HOLD} state_t;

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  // The settle timer counts down; the snapshot happens on the cycle it reads zero.
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CLASS_W-1:0] IDX_LAST = CLASS_W'(OUT_SIZE - 1);

  state_t                        state, state_d;
  logic [CNT_W-1:0]              cnt, cnt_d;
  logic [CLASS_W-1:0]            idx, idx_d;
  logic [CLASS_W-1:0]            best_idx, best_idx_d;
  logic signed [DATA_WIDTH-1:0]  best, best_d;
  logic                          valid_d;
  logic [CLASS_W-1:0]            class_idx_d;
  logic                          snap_ld;
  logic signed [DATA_WIDTH-1:0]  snap [OUT_SIZE];
  logic                          better;

  // Strict compare keeps the earlier (lower) index on ties.
  assign better = (snap[idx] > best);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    best_d      = best;
    best_idx_d  = best_idx;
    valid_d     = class_valid;
    class_idx_d = class_idx;
    snap_ld     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (start) begin
          cnt_d = CNT_LOAD;
        end else if (cnt == '0) begin
          snap_ld    = 1'b1;
          best_d     = $signed(scores_in[0]);
          best_idx_d = '0;
          idx_d      = CLASS_W'(1);
          if (OUT_SIZE == 1) begin
            state_d     = HOLD;
            valid_d     = 1'b1;
            class_idx_d = '0;
          end else begin
            state_d = SCAN;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      SCAN: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          if (better) begin
            best_d     = snap[idx];
            best_idx_d = idx;
          end
          if (idx == IDX_LAST) begin
            state_d     = HOLD;
            valid_d     = 1'b1;
            class_idx_d = better ? idx : best_idx;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      HOLD: begin
        // start is only honoured here when the handshake completes in the same cycle.
        if (class_ready) begin
          valid_d = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = start ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      best        <= '0;
      best_idx    <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      best        <= best_d;
      best_idx    <= best_idx_d;
      class_valid <= valid_d;
      class_idx   <= class_idx_d;
      busy        <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_SIZE; i++) snap[i] <= '0;
    end else if (snap_ld) begin
      for (int i = 0; i < OUT_SIZE; i++) snap[i] <= $signed(scores_in[i]);
    end
  end

`ifdef ARGMAX_SCORE_OUT_EN
  // Loaded together with class_idx on entry to HOLD; best_d is the final best then.
  always_ff @(posedge clk) begin
    if (rst) begin
      class_score <= '0;
    end else if (valid_d && !class_valid) begin
      class_score <= best_d;
    end
  end
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
module tb_argmax_classifier;

  localparam int DW     = 16;
  localparam int NOUT   = 3;
  localparam int SETTLE = 34;
  localparam int CW     = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic [NOUT-1:0][DW-1:0]   scores_in = '0;
  logic                      class_ready = 1'b0;
  logic                      class_valid;
  logic [CW-1:0]             class_idx;
  logic                      busy;
`ifdef ARGMAX_SCORE_OUT_EN
  logic signed [DW-1:0]      class_score;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  argmax_classifier #(.DATA_WIDTH(DW), .OUT_SIZE(NOUT), .SETTLE_CYC(SETTLE), .CLASS_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scores_in   (scores_in),
    .class_ready (class_ready),
    .class_valid (class_valid),
    .class_idx   (class_idx),
`ifdef ARGMAX_SCORE_OUT_EN
    .class_score (class_score),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a run is a timeline measured in cycles since start.
  // The scores present in cycle SETTLE decide the result, which appears in
  // cycle SETTLE+NOUT and stays until the handshake.
  bit              m_running = 0, m_holding = 0;
  int              m_t = 0;
  int              m_pend_idx = 0;
  int              m_pend_score = 0;
  bit              m_valid = 0, m_busy = 0;
  int              m_idx = 0, m_score = 0;

  task automatic argmax(input logic [NOUT-1:0][DW-1:0] v, output int bi, output int bs);
    bi = 0;
    bs = int'($signed(v[0]));
    for (int i = 1; i < NOUT; i++)
      if (int'($signed(v[i])) > bs) begin
        bi = i;
        bs = int'($signed(v[i]));
      end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_running = 0; m_holding = 0; m_valid = 0; m_idx = 0; m_score = 0;
    end else if (m_holding) begin
      if (class_ready) begin
        m_holding = 0;
        m_valid   = 0;
        if (start) begin m_running = 1; m_t = 1; end
      end
    end else if (m_running) begin
      if (start) m_t = 1;
      else begin
        if (m_t == SETTLE) argmax(scores_in, m_pend_idx, m_pend_score);
        m_t++;
        if (m_t == SETTLE + NOUT) begin
          m_running = 0; m_holding = 1; m_valid = 1;
          m_idx = m_pend_idx; m_score = m_pend_score;
        end
      end
    end else if (start) begin
      m_running = 1; m_t = 1;
    end
    m_busy = m_running | m_holding;
    #1;
    chk("class_valid", 32'(class_valid), 32'(m_valid));
    chk("class_idx", 32'(class_idx), 32'(m_idx));
    chk("busy", 32'(busy), 32'(m_busy));
`ifdef ARGMAX_SCORE_OUT_EN
    chk("class_score", 32'(class_score), 32'(m_score));
`endif
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set3(input int a, input int b, input int c);
    scores_in[0] = DW'(a);
    scores_in[1] = DW'(b);
    scores_in[2] = DW'(c);
  endtask

  task automatic go_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle number (start cycle = 0) at which class_valid is first seen.
  task automatic wait_valid(output int cyc);
    int n = 0;
    while (!class_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("valid_timeout", 32'(n), 32'd0);
    cyc = n + 1;
  endtask

  task automatic handshake();
    class_ready = 1'b1;
    step(1);
    class_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input int a, input int b, input int c, input int exp_idx);
    int cyc;
    set3(a, b, c);
    go_start();
    wait_valid(cyc);
    chk({name, "_latency"}, 32'(cyc), 32'd37);
    chk({name, "_idx"}, 32'(class_idx), 32'(exp_idx));
    handshake();
  endtask

  initial begin
    int cyc;
    step(3);
    chk("reset_valid", 32'(class_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(2);

    // 1 and 3: basic result, then hold with ready low before the handshake
    set3(5, 20, 7);
    go_start();
    chk("busy_cycle1", 32'(busy), 32'd1);
    wait_valid(cyc);
    chk("latency", 32'(cyc), 32'd37);
    chk("idx_5_20_7", 32'(class_idx), 32'd1);
`ifdef ARGMAX_SCORE_OUT_EN
    chk("score_5_20_7", 32'(class_score), 32'd20);
`endif
    step(10);
    chk("hold_valid", 32'(class_valid), 32'd1);
    chk("hold_idx", 32'(class_idx), 32'd1);
    handshake();
    chk("after_hs_valid", 32'(class_valid), 32'd0);
    chk("after_hs_busy", 32'(busy), 32'd0);
    chk("after_hs_idx", 32'(class_idx), 32'd1);

    // 2: ties, zero vector, negative scores
    run_vec("tie", 9, 9, 3, 0);
    run_vec("zero", 0, 0, 0, 0);
    run_vec("neg", -4, -1, -9, 1);
    run_vec("last", -32768, 32767, 32767, 1);
    run_vec("max2", 1, 2, 3, 2);

    // 4: restart during SCAN drops the first run
    set3(1, 2, 30);
    go_start();
    step(35);
    go_start();
    wait_valid(cyc);
    chk("restart_latency", 32'(cyc), 32'd37);
    chk("restart_idx", 32'(class_idx), 32'd2);
    handshake();

    // 5: reset in WAIT
    go_start();
    step(19);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_valid", 32'(class_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    step(50);
    chk("rst_no_valid", 32'(class_valid), 32'd0);

    // 6: scores changing after the snapshot do not matter
    set3(5, 20, 7);
    go_start();
    step(34);
    set3(99, 0, 0);
    wait_valid(cyc);
    chk("late_change_idx", 32'(class_idx), 32'd1);
`ifdef ARGMAX_SCORE_OUT_EN
    chk("late_change_score", 32'(class_score), 32'd20);
`endif
    handshake();

    // random phase, including start during HOLD and occasional reset
    for (int k = 0; k < 4000; k++) begin
      start       = ($urandom_range(0, 29) == 0);
      class_ready = ($urandom_range(0, 2) != 0);
      rst         = ($urandom_range(0, 799) == 0);
      for (int i = 0; i < NOUT; i++)
        scores_in[i] = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 7) - 4) : DW'($urandom);
      step(1);
    end
    rst = 1'b0;
    start = 1'b0;
    class_ready = 1'b1;
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
